event_state_tracker: RTL and testbench

Parametrised successor to the fixed five-input status register used by the front-panel logic. It captures rising edges on N event lines into sticky pending bits and resolves them by fixed priority into a registered state code. Higher priority preempts immediately; lower priority takes over only after a minimum hold time. Downstream display and buzzer logic consume `state`, `state_valid` and `state_chg`, and return `ack`.

---
 rtl/event_state_tracker_if.sv | 25 ++
 rtl/event_state_tracker.sv | 92 +++++++++
 tb/tb_event_state_tracker.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/event_state_tracker_if.sv
// Event/status bundle between front-panel event sources, display/buzzer consumer and the tracker.
// master drives events, enables and ack; slave (the tracker) returns the resolved state.
interface event_state_tracker_if #(
  parameter int N_EVT  = 5,
  parameter int CODE_W = 3
);
  logic [N_EVT-1:0]  evt_in;
  logic [N_EVT-1:0]  evt_en;
  logic              ack;
  logic [CODE_W-1:0] state;
  logic              state_valid;
  logic              state_chg;
  logic [N_EVT-1:0]  pending;
  logic              hold_busy;

  modport master (
    output evt_in, evt_en, ack,
    input  state, state_valid, state_chg, pending, hold_busy
  );

  modport slave (
    input  evt_in, evt_en, ack,
    output state, state_valid, state_chg, pending, hold_busy
  );
endinterface

// File: rtl/event_state_tracker.sv
// Sticky rising-edge capture on N event lines, resolved by fixed priority into a registered state code.
// Latency: rise -> pending after 1 edge, -> state after 2; ack is ignored while the hold window runs.
module event_state_tracker #(
  parameter int N_EVT    = 5,
  parameter int CODE_W   = 3,
  parameter int HOLD_CYC = 4
) (
  input logic                 clk,
  input logic                 rst,
  event_state_tracker_if.slave bus
);

  localparam int HOLD_W = (HOLD_CYC < 1) ? 1 : $clog2(HOLD_CYC + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYC);

  logic [N_EVT-1:0]  evt_prev;
  logic [N_EVT-1:0]  pending_q;
  logic [N_EVT-1:0]  rise;
  logic [N_EVT-1:0]  pend_clr;
  logic [N_EVT-1:0]  pending_d;
  logic [CODE_W-1:0] state_q;
  logic [CODE_W-1:0] cand;
  logic              cand_vld;
  logic              state_valid_q;
  logic              state_chg_q;
  logic              load;
  logic              drop;
  logic              hold_zero;
  logic [HOLD_W-1:0] hold_cnt;

  assign rise      = bus.evt_in & ~evt_prev & bus.evt_en;
  assign hold_zero = (hold_cnt == '0);

  // Lowest index wins; only registered pending feeds the candidate.
  always_comb begin
    cand     = '0;
    cand_vld = 1'b0;
    for (int i = N_EVT - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        cand     = CODE_W'(i);
        cand_vld = 1'b1;
      end
    end
  end

  assign load = cand_vld && (!state_valid_q || (cand < state_q) || hold_zero);
  assign drop = !load && bus.ack && hold_zero;

  always_comb begin
    pend_clr = '0;
    for (int i = 0; i < N_EVT; i++) begin
      pend_clr[i] = load && (cand == CODE_W'(i));
    end
  end

  // Clearing beats a same-cycle rise only for the loaded or masked channel.
  assign pending_d = (pending_q | rise) & bus.evt_en & ~pend_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_prev      <= '0;
      pending_q     <= '0;
      state_q       <= '0;
      state_valid_q <= 1'b0;
      state_chg_q   <= 1'b0;
      hold_cnt      <= '0;
    end else begin
      evt_prev    <= bus.evt_in;
      pending_q   <= pending_d;
      state_chg_q <= load;
      if (load) begin
        state_q       <= cand;
        state_valid_q <= 1'b1;
        hold_cnt      <= HOLD_INIT;
      end else begin
        if (drop) begin
          state_valid_q <= 1'b0;
        end
        if (!hold_zero) begin
          hold_cnt <= hold_cnt - 1'b1;
        end
      end
    end
  end

  assign bus.state       = state_q;
  assign bus.state_valid = state_valid_q;
  assign bus.state_chg   = state_chg_q;
  assign bus.pending     = pending_q;
  assign bus.hold_busy   = !hold_zero;

endmodule

// File: tb/tb_event_state_tracker.sv
// Scoreboarded bench: reference model pushes expected outputs per edge, a negedge monitor pops and compares.
module tb_event_state_tracker;
  localparam int N  = 5;
  localparam int CW = 3;
  localparam int HC = 4;
  localparam logic [N-1:0] ALL = 5'b11111;

  typedef struct {
    int           st;
    bit           vld;
    bit           chg;
    bit [N-1:0]   pend;
    bit           busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  int         m_state;
  bit         m_valid;
  bit         m_chg;
  bit [N-1:0] m_pend;
  bit [N-1:0] m_prev;
  int         m_hold;

  always #5 clk = ~clk;

  event_state_tracker_if #(.N_EVT(N), .CODE_W(CW)) bus ();

  event_state_tracker #(.N_EVT(N), .CODE_W(CW), .HOLD_CYC(HC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_valid = 0; m_chg = 0; m_pend = '0; m_prev = '0; m_hold = 0;
  endtask

  // Behavioural rules: priority pick, preempt-or-wait-for-hold, ack only when idle.
  task automatic model_step(input bit [N-1:0] e, input bit [N-1:0] en, input bit a);
    bit [N-1:0] rise;
    bit [N-1:0] np;
    int cand;
    bit ld;
    rise = e & ~m_prev & en;
    cand = -1;
    for (int i = N - 1; i >= 0; i--) if (m_pend[i]) cand = i;
    ld = (cand >= 0) && (!m_valid || cand < m_state || m_hold == 0);
    np = (m_pend | rise) & en;
    if (ld) begin
      np[cand] = 1'b0;
      m_state  = cand;
      m_valid  = 1'b1;
      m_hold   = HC;
    end else begin
      if (a && m_hold == 0) m_valid = 1'b0;
      if (m_hold > 0) m_hold--;
    end
    m_chg  = ld;
    m_pend = np;
    m_prev = e;
  endtask

  task automatic cycle(input logic [N-1:0] e, input logic [N-1:0] en, input logic a);
    exp_t x;
    bus.evt_in = e;
    bus.evt_en = en;
    bus.ack    = a;
    @(posedge clk);
    #1;
    model_step(e, en, a);
    x.st = m_state; x.vld = m_valid; x.chg = m_chg; x.pend = m_pend; x.busy = (m_hold != 0);
    sb.push_back(x);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_state"}, 32'(bus.state), 0);
    chk({nm, "_valid"}, 32'(bus.state_valid), 0);
    chk({nm, "_chg"}, 32'(bus.state_chg), 0);
    chk({nm, "_pend"}, 32'(bus.pending), 0);
    chk({nm, "_busy"}, 32'(bus.hold_busy), 0);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("sb_state", 32'(bus.state), 32'(x.st));
        chk("sb_valid", 32'(bus.state_valid), 32'(x.vld));
        chk("sb_chg", 32'(bus.state_chg), 32'(x.chg));
        chk("sb_pend", 32'(bus.pending), 32'(x.pend));
        chk("sb_busy", 32'(bus.hold_busy), 32'(x.busy));
      end
    end
  end

  initial begin : stim
    rst = 1'b1;
    bus.evt_in = '0;
    bus.evt_en = ALL;
    bus.ack    = 1'b0;
    model_reset();
    #1;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single event on channel 3
    cycle(5'b01000, ALL, 0);
    chk("single_pend", 32'(bus.pending), 32'h08);
    chk("single_notyet", 32'(bus.state_valid), 0);
    cycle('0, ALL, 0);
    chk("single_state", 32'(bus.state), 3);
    chk("single_chg", 32'(bus.state_chg), 1);
    chk("single_pend_clr", 32'(bus.pending), 0);

    // Preemption by channel 0 during the hold
    cycle(5'b00001, ALL, 0);
    chk("pre_busy", 32'(bus.hold_busy), 1);
    cycle('0, ALL, 0);
    chk("pre_state", 32'(bus.state), 0);
    chk("pre_busy2", 32'(bus.hold_busy), 1);

    // Hold then takeover: channel 1 loads, channel 4 waits out the hold
    repeat (6) cycle('0, ALL, 0);
    cycle(5'b00010, ALL, 0);
    cycle('0, ALL, 0);
    chk("take_load1", 32'(bus.state), 1);
    cycle(5'b10000, ALL, 0);
    repeat (3) cycle('0, ALL, 0);
    chk("take_still1", 32'(bus.state), 1);
    cycle('0, ALL, 0);
    chk("take_state4", 32'(bus.state), 4);

    // ack during hold is ignored; ack after the hold drops valid
    cycle('0, ALL, 1);
    chk("ack_held", 32'(bus.state_valid), 1);
    repeat (3) cycle('0, ALL, 0);
    cycle('0, ALL, 1);
    chk("ack_drop_valid", 32'(bus.state_valid), 0);
    chk("ack_keep_state", 32'(bus.state), 4);

    // ack together with a candidate: the load wins
    cycle(5'b01000, ALL, 0);
    cycle('0, ALL, 0);
    repeat (4) cycle('0, ALL, 0);
    cycle(5'b00100, ALL, 0);
    cycle('0, ALL, 1);
    chk("ack_load_state", 32'(bus.state), 2);
    chk("ack_load_valid", 32'(bus.state_valid), 1);

    // Mask plus simultaneous rises
    repeat (5) cycle('0, ALL, 1);
    cycle(5'b10111, 5'b11101, 0);
    chk("mask_pend", 32'(bus.pending), 32'h15);
    for (int i = 1; i <= 11; i++) begin
      cycle('0, 5'b11101, 0);
      chk("mask_never1", 32'(bus.state == 3'd1), 0);
      if (i == 1)  chk("mask_seq0", 32'(bus.state), 0);
      if (i == 6)  chk("mask_seq2", 32'(bus.state), 2);
      if (i == 11) chk("mask_seq4", 32'(bus.state), 4);
    end

    // Async reset mid-hold, release with channel 2 high
    cycle(5'b01000, ALL, 1);
    cycle('0, ALL, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("arst");
    model_reset();
    bus.evt_in = 5'b00100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle(5'b00100, ALL, 0);
    chk("arst_pend", 32'(bus.pending), 32'h04);
    cycle(5'b00100, ALL, 0);
    chk("arst_state", 32'(bus.state), 2);
    chk("arst_valid", 32'(bus.state_valid), 1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] e;
      logic [N-1:0] en;
      e  = N'($urandom) & N'($urandom) & N'($urandom);
      en = ($urandom_range(0, 7) == 0) ? N'($urandom) : ALL;
      cycle(e, en, ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
